// File: rtl/fft_bfly_pipe.sv
// fft_bfly_pipe: pipelined radix-2 DIT butterfly, SUM = A + B*W, DIF = A - B*W.
// Complex fixed-point operands; the product is rounded half-up, the outputs saturate.
// Latency is 3 enabled cycles. Valid/ready flow control. Sticky overflow flag.
//
// Optional build macro: BFLY_SCALE_EN. When defined, each S3 result is scaled
// by 1/2 with round-half-up before saturation.
//
// Ports:
//   clock, reset             rising-edge clock; asynchronous active-high reset
//   in_valid / in_ready      input handshake (in_ready = pipeline advance enable)
//   a_re, a_im, b_re, b_im   operands, signed DATA_W
//   w_re, w_im               twiddle, signed Q1.(TW_W-1)
//   out_valid / out_ready    output handshake
//   sum_re, sum_im           A + B*W, saturated to DATA_W
//   dif_re, dif_im           A - B*W, saturated to DATA_W
//   beat_ovf                 saturation occurred in the current output beat
//   ovf_sticky / ovf_clr     sticky OR of consumed beat_ovf; synchronous clear
module fft_bfly_pipe #(
  parameter int DATA_W = 16,
  parameter int TW_W   = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] a_re,
  input  logic signed [DATA_W-1:0] a_im,
  input  logic signed [DATA_W-1:0] b_re,
  input  logic signed [DATA_W-1:0] b_im,
  input  logic signed [TW_W-1:0]   w_re,
  input  logic signed [TW_W-1:0]   w_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] sum_re,
  output logic signed [DATA_W-1:0] sum_im,
  output logic signed [DATA_W-1:0] dif_re,
  output logic signed [DATA_W-1:0] dif_im,
  output logic                     beat_ovf,
  output logic                     ovf_sticky,
  input  logic                     ovf_clr
);

  localparam int PW = DATA_W + TW_W;  // raw product width
  localparam int CW = PW + 1;         // complex product sum width
  localparam int RW = DATA_W + 2;     // rounded product width
  localparam int SW = DATA_W + 3;     // butterfly add/sub width

  localparam logic signed [SW-1:0] MAXV = {4'b0000, {(DATA_W-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {4'b1111, {(DATA_W-1){1'b0}}};
  localparam logic signed [CW-1:0] RND  = CW'(1) <<< (TW_W-2);

  logic en;
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  // Stage 1: operand A and the four partial products
  logic                     v1;
  logic signed [DATA_W-1:0] a1_re, a1_im;
  logic signed [PW-1:0]     m_rr, m_ii, m_ri, m_ir;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v1    <= 1'b0;
      a1_re <= '0;
      a1_im <= '0;
      m_rr  <= '0;
      m_ii  <= '0;
      m_ri  <= '0;
      m_ir  <= '0;
    end else if (en) begin
      v1    <= in_valid;
      a1_re <= a_re;
      a1_im <= a_im;
      m_rr  <= PW'(b_re) * PW'(w_re);
      m_ii  <= PW'(b_im) * PW'(w_im);
      m_ri  <= PW'(b_re) * PW'(w_im);
      m_ir  <= PW'(b_im) * PW'(w_re);
    end
  end

  // Stage 2: complex product with round-half-up; no saturation here
  logic signed [CW-1:0] pre_x, pim_x;
  assign pre_x = CW'(m_rr) - CW'(m_ii) + RND;
  assign pim_x = CW'(m_ri) + CW'(m_ir) + RND;

  logic                     v2;
  logic signed [DATA_W-1:0] a2_re, a2_im;
  logic signed [RW-1:0]     p2_re, p2_im;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v2    <= 1'b0;
      a2_re <= '0;
      a2_im <= '0;
      p2_re <= '0;
      p2_im <= '0;
    end else if (en) begin
      v2    <= v1;
      a2_re <= a1_re;
      a2_im <= a1_im;
      p2_re <= RW'(pre_x >>> (TW_W-1));
      p2_im <= RW'(pim_x >>> (TW_W-1));
    end
  end

  // Stage 3: add/sub, optional halving, saturation. Returns {ovf, value}.
  function automatic logic [DATA_W:0] sat(input logic signed [SW-1:0] x);
    logic signed [SW-1:0] y;
    y = x;
`ifdef BFLY_SCALE_EN
    y = (x + SW'(1)) >>> 1;
`else
    y = x;
`endif
    if (y > MAXV)      sat = {1'b1, MAXV[DATA_W-1:0]};
    else if (y < MINV) sat = {1'b1, MINV[DATA_W-1:0]};
    else               sat = {1'b0, y[DATA_W-1:0]};
  endfunction

  logic signed [SW-1:0] t_sr, t_si, t_dr, t_di;
  logic [DATA_W:0]      r_sr, r_si, r_dr, r_di;

  assign t_sr = SW'(a2_re) + SW'(p2_re);
  assign t_si = SW'(a2_im) + SW'(p2_im);
  assign t_dr = SW'(a2_re) - SW'(p2_re);
  assign t_di = SW'(a2_im) - SW'(p2_im);
  assign r_sr = sat(t_sr);
  assign r_si = sat(t_si);
  assign r_dr = sat(t_dr);
  assign r_di = sat(t_di);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      sum_re    <= '0;
      sum_im    <= '0;
      dif_re    <= '0;
      dif_im    <= '0;
      beat_ovf  <= 1'b0;
    end else if (en) begin
      out_valid <= v2;
      sum_re    <= r_sr[DATA_W-1:0];
      sum_im    <= r_si[DATA_W-1:0];
      dif_re    <= r_dr[DATA_W-1:0];
      dif_im    <= r_di[DATA_W-1:0];
      beat_ovf  <= r_sr[DATA_W] | r_si[DATA_W] | r_dr[DATA_W] | r_di[DATA_W];
    end
  end

  // A consumed overflowing beat sets the flag and takes priority over the clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                 ovf_sticky <= 1'b0;
    else if (out_valid & out_ready & beat_ovf) ovf_sticky <= 1'b1;
    else if (ovf_clr)                          ovf_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_fft_bfly_pipe.sv
// tb_fft_bfly_pipe: scoreboard bench for fft_bfly_pipe (DATA_W = TW_W = 16).
module tb_fft_bfly_pipe;
  localparam int DW = 16;
  localparam int TW = 16;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                 reset, in_valid, in_ready, out_valid, out_ready;
  logic signed [DW-1:0] a_re, a_im, b_re, b_im;
  logic signed [TW-1:0] w_re, w_im;
  logic signed [DW-1:0] sum_re, sum_im, dif_re, dif_im;
  logic                 beat_ovf, ovf_sticky, ovf_clr;

  fft_bfly_pipe #(.DATA_W(DW), .TW_W(TW)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .w_re(w_re), .w_im(w_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum_re(sum_re), .sum_im(sum_im), .dif_re(dif_re), .dif_im(dif_im),
    .beat_ovf(beat_ovf), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );

  typedef struct {
    longint sr, si, dr, di;
    longint ovf;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   exp_sticky = 1'b0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic longint satv(input longint x, output bit o);
    longint hi, lo;
    hi = (longint'(1) << (DW-1)) - 1;
    lo = -(longint'(1) << (DW-1));
    o  = 1'b0;
    if (x > hi) begin o = 1'b1; return hi; end
    if (x < lo) begin o = 1'b1; return lo; end
    return x;
  endfunction

  function automatic exp_t model(input longint ar, ai, br, bi, wr, wi);
    exp_t   e;
    longint pre, pim, pr, pi;
    longint s[4];
    bit     o[4];
    pre = br*wr - bi*wi;
    pim = br*wi + bi*wr;
    pr  = (pre + (longint'(1) << (TW-2))) >>> (TW-1);
    pi  = (pim + (longint'(1) << (TW-2))) >>> (TW-1);
    s[0] = ar + pr; s[1] = ai + pi; s[2] = ar - pr; s[3] = ai - pi;
    for (int i = 0; i < 4; i++) begin
`ifdef BFLY_SCALE_EN
      s[i] = (s[i] + 1) >>> 1;
`endif
      s[i] = satv(s[i], o[i]);
    end
    e.sr = s[0]; e.si = s[1]; e.dr = s[2]; e.di = s[3];
    e.ovf = longint'(o[0] | o[1] | o[2] | o[3]);
    return e;
  endfunction

  // Monitor: inputs/outputs are stable at the falling edge; events here
  // take effect at the following rising edge.
  always @(negedge clock) begin
    if (!reset) begin
      exp_t e;
      bit   set_ev;
      set_ev = 1'b0;
      check("ovf_sticky", ovf_sticky, exp_sticky);
      if (in_valid && in_ready)
        q.push_back(model(a_re, a_im, b_re, b_im, w_re, w_im));
      if (out_valid) begin
        if (q.size() == 0) check("out_unexpected", out_valid, 0);
        else begin
          e = q[0];
          check("sum_re", sum_re, e.sr);
          check("sum_im", sum_im, e.si);
          check("dif_re", dif_re, e.dr);
          check("dif_im", dif_im, e.di);
          check("beat_ovf", beat_ovf, e.ovf);
          if (out_ready) begin
            void'(q.pop_front());
            set_ev = (e.ovf != 0);
          end
        end
      end
      if (set_ev)       exp_sticky = 1'b1;
      else if (ovf_clr) exp_sticky = 1'b0;
    end
  end

  task automatic drive(input longint ar, ai, br, bi, wr, wi);
    bit ok;
    a_re = DW'(ar); a_im = DW'(ai); b_re = DW'(br); b_im = DW'(bi);
    w_re = TW'(wr); w_im = TW'(wi);
    in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock); ok = in_ready;
      @(posedge clock); #1;
      if (ok) begin in_valid = 1'b0; return; end
    end
    check("accept_timeout", in_ready, 1);
    in_valid = 1'b0;
  endtask

  // Single beat with out_ready held high: out_valid must rise exactly 3 cycles on
  task automatic single(input longint ar, ai, br, bi, wr, wi);
    drive(ar, ai, br, bi, wr, wi);
    @(negedge clock); check("lat_c1", out_valid, 0);
    @(negedge clock); check("lat_c2", out_valid, 0);
    @(negedge clock); check("lat_c3", out_valid, 1);
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0; w_re = '0; w_im = '0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum_re", sum_re, 0);
    check("rst_dif_im", dif_im, 0);
    check("rst_beat_ovf", beat_ovf, 0);
    check("rst_sticky", ovf_sticky, 0);
    @(posedge clock); #1; reset = 1'b0;
    check("in_ready_after_rst", in_ready, 1);

    // Directed vectors
    single(1000, 0, 2000, 0, 16'h4000, 0);
    single(0, 0, 2000, 400, 0, -16384);
    single(0, 0, 3, 0, 16'h4000, 0);
    single(-30000, 0, 30000, 0, 16'h4000, 0);
    single(30000, 0, 30000, 0, 16'h4000, 0);
    idle(2);
    // Clear with nothing overflowing in flight
    ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0;
    @(negedge clock); check("sticky_cleared", ovf_sticky, 0);
    @(posedge clock); #1;

    // w = -1, b = most negative: product is +2^(DW-1), saturates only at S3
    single(0, 0, -32768, 0, -32768, 0);
    idle(2);
    ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0;

    // Clear in the same cycle an overflowing beat is consumed: set wins
    drive(30000, 0, 30000, 0, 16'h4000, 0);
    idle(2);
    ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0;
    @(negedge clock); check("sticky_set_wins", ovf_sticky, 1);
    @(posedge clock); #1;

    // Back-pressure: 8 beats, out_ready low for cycles 5-7
    fork
      for (int i = 0; i < 8; i++) drive(100*i, -50*i, 1000 + i, 7*i, 16'h4000, 16'h2000);
      begin
        idle(5);
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clock); check("stall_in_ready", in_ready, 0);
          @(posedge clock); #1;
        end
        out_ready = 1'b1;
      end
    join
    idle(6);

    // Random beats with random back-pressure
    fork
      for (int i = 0; i < 20; i++)
        drive($signed(DW'($urandom)), $signed(DW'($urandom)), $signed(DW'($urandom)),
              $signed(DW'($urandom)), $signed(TW'($urandom)), $signed(TW'($urandom)));
      begin
        repeat (60) begin out_ready = ($urandom_range(0, 3) != 0); idle(1); end
        out_ready = 1'b1;
      end
    join
    idle(6);
    ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0;

    // Reset mid-flight: two beats accepted, reset pulse across the next edge
    drive(30000, 0, 30000, 0, 16'h4000, 0);
    drive(5, 5, 5, 5, 16'h4000, 0);
    #8;
    reset = 1'b1;
    q.delete();
    exp_sticky = 1'b0;
    #2;
    reset = 1'b0;
    check("mrst_out_valid", out_valid, 0);
    check("mrst_sum_re", sum_re, 0);
    check("mrst_sum_im", sum_im, 0);
    check("mrst_dif_re", dif_re, 0);
    check("mrst_beat_ovf", beat_ovf, 0);
    check("mrst_sticky", ovf_sticky, 0);
    @(posedge clock); #1;
    single(123, -45, 2000, 400, 0, -16384);
    idle(4);

    check("sb_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
